// File: rtl/match_mon_pkg.sv
// Shared types and default sizing for the match event monitor.
package match_mon_pkg;

    localparam int CNT_W_DEF  = 16;
    localparam int WINDOW_DEF = 256;
    localparam int THRESH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        TRACK = 2'd2,
        ALARM = 2'd3
    } mon_state_e;

endpackage

// File: rtl/match_event_monitor_sat_counter.sv
// Saturating up-counter with clear (highest priority), parallel load and increment.
module sat_counter #(
    parameter int             W   = 8,
    parameter logic [W-1:0]   MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i && (cnt_q != MAX)) begin
            cnt_d = cnt_q + ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/match_event_monitor.sv
// Monitors match pulses: total count, inter-match gap and a sticky windowed-rate alarm.
module match_event_monitor
    import match_mon_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int WINDOW = WINDOW_DEF,
    parameter int THRESH = THRESH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          match,
    input  logic                          enable,
    input  logic                          clr,
    output logic [CNT_W-1:0]              match_count,
    output logic [CNT_W-1:0]              last_gap,
    output logic [$clog2(THRESH+1)-1:0]   win_matches,
    output logic                          alarm,
    output logic                          irq,
    output logic [1:0]                    state_o
);

    localparam int                 WM_W     = $clog2(THRESH + 1);
    localparam logic [CNT_W-1:0]   WIN_LAST = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0]   C_ONE    = CNT_W'(1);
    localparam logic [WM_W-1:0]    WM_ONE   = WM_W'(1);
    localparam logic [WM_W-1:0]    WM_MAX   = WM_W'(THRESH);

    mon_state_e        state_q, state_d;
    logic              alarm_q, alarm_d;
    logic              irq_q, irq_d;
    logic [CNT_W-1:0]  window_cnt_q, window_cnt_d;
    logic [CNT_W-1:0]  last_gap_q, last_gap_d;
    logic [CNT_W-1:0]  gap_cnt;
    logic [WM_W-1:0]   win_next;
    logic              smatch, dis, wrap, hit;

    assign smatch = enable & match;
    assign dis    = ~enable & (state_q != ALARM);
    assign wrap   = enable & (window_cnt_q == WIN_LAST);

    sat_counter #(.W(CNT_W)) u_match_cnt (
        .clk(clk), .rst(rst), .clr_i(clr), .load_i(1'b0), .load_val_i('0),
        .inc_i(smatch), .cnt_o(match_count)
    );

    sat_counter #(.W(CNT_W)) u_gap_cnt (
        .clk(clk), .rst(rst), .clr_i(clr | dis | smatch), .load_i(1'b0), .load_val_i('0),
        .inc_i(enable), .cnt_o(gap_cnt)
    );

    // A match landing in the wrap cycle opens the new window with a count of one.
    sat_counter #(.W(WM_W), .MAX(WM_MAX)) u_win_cnt (
        .clk(clk), .rst(rst), .clr_i(clr | dis), .load_i(wrap),
        .load_val_i(smatch ? WM_ONE : '0), .inc_i(smatch), .cnt_o(win_matches)
    );

    // Predicts the window-match value after this edge to detect reaching THRESH.
    always_comb begin
        win_next = win_matches;
        if (wrap) begin
            win_next = smatch ? WM_ONE : '0;
        end else if (smatch && (win_matches != WM_MAX)) begin
            win_next = win_matches + WM_ONE;
        end else begin
            win_next = win_matches;
        end
    end

    assign hit = smatch & (win_next == WM_MAX);

    // Rate-window position and last-gap datapath.
    always_comb begin
        window_cnt_d = window_cnt_q;
        last_gap_d   = last_gap_q;
        if (clr) begin
            window_cnt_d = '0;
            last_gap_d   = '0;
        end else if (dis) begin
            window_cnt_d = '0;
        end else if (enable) begin
            window_cnt_d = wrap ? '0 : window_cnt_q + C_ONE;
            if (smatch && ((state_q == TRACK) || (state_q == ALARM))) begin
                last_gap_d = (gap_cnt == '1) ? gap_cnt : gap_cnt + C_ONE;
            end else begin
                last_gap_d = last_gap_q;
            end
        end else begin
            window_cnt_d = window_cnt_q;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = enable ? ARMED : IDLE;
        end else if (state_q == ALARM) begin
            state_d = ALARM;
        end else if (!enable) begin
            state_d = IDLE;
        end else if (hit) begin
            state_d = ALARM;
        end else begin
            case (state_q)
                IDLE:    state_d = ARMED;
                ARMED:   state_d = smatch ? TRACK : ARMED;
                TRACK:   state_d = TRACK;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: sticky alarm with a one-cycle irq on entry to ALARM.
    always_comb begin
        alarm_d = alarm_q;
        irq_d   = 1'b0;
        if (clr) begin
            alarm_d = 1'b0;
        end else if ((state_q != ALARM) && (state_d == ALARM)) begin
            alarm_d = 1'b1;
            irq_d   = 1'b1;
        end else begin
            alarm_d = alarm_q;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            alarm_q      <= 1'b0;
            irq_q        <= 1'b0;
            window_cnt_q <= '0;
            last_gap_q   <= '0;
        end else begin
            state_q      <= state_d;
            alarm_q      <= alarm_d;
            irq_q        <= irq_d;
            window_cnt_q <= window_cnt_d;
            last_gap_q   <= last_gap_d;
        end
    end

    assign last_gap = last_gap_q;
    assign alarm    = alarm_q;
    assign irq      = irq_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_match_event_monitor.sv
// Directed scoreboard bench for match_event_monitor with CNT_W=8, WINDOW=16, THRESH=3.
module tb_match_event_monitor;

    localparam int CNT_W  = 8;
    localparam int WINDOW = 16;
    localparam int THRESH = 3;

    logic       clk = 1'b0;
    logic       rst, match, enable, clr;
    logic [7:0] match_count, last_gap;
    logic [1:0] win_matches;
    logic       alarm, irq;
    logic [1:0] state_o;

    typedef struct {
        string      tag;
        logic [7:0] mc;
        logic [7:0] lg;
        logic [1:0] wm;
        logic       al;
        logic       ir;
        logic [1:0] st;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    match_event_monitor #(.CNT_W(CNT_W), .WINDOW(WINDOW), .THRESH(THRESH)) dut (
        .clk(clk), .rst(rst), .match(match), .enable(enable), .clr(clr),
        .match_count(match_count), .last_gap(last_gap), .win_matches(win_matches),
        .alarm(alarm), .irq(irq), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic e, input logic m, input logic c);
        rst = r; enable = e; match = m; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input logic e);
        for (int i = 0; i < n; i++) drive(1'b0, e, 1'b0, 1'b0);
    endtask

    task automatic cmp(input string tag, input string fld, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, exp);
        end
    endtask

    // Push the expectation, apply one cycle of stimulus, then pop and compare.
    task automatic chk(input string tag, input logic r, input logic e, input logic m, input logic c,
                       input logic [7:0] mc, input logic [7:0] lg, input logic [1:0] wm,
                       input logic al, input logic ir, input logic [1:0] st);
        exp_t x;
        x.tag = tag; x.mc = mc; x.lg = lg; x.wm = wm; x.al = al; x.ir = ir; x.st = st;
        sb_q.push_back(x);
        drive(r, e, m, c);
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            x = sb_q.pop_front();
            cmp(x.tag, "match_count", match_count, x.mc);
            cmp(x.tag, "last_gap", last_gap, x.lg);
            cmp(x.tag, "win_matches", {6'd0, win_matches}, {6'd0, x.wm});
            cmp(x.tag, "alarm", {7'd0, alarm}, {7'd0, x.al});
            cmp(x.tag, "irq", {7'd0, irq}, {7'd0, x.ir});
            cmp(x.tag, "state", {6'd0, state_o}, {6'd0, x.st});
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; match = 1'b0; clr = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b0, 2'd0);

        // Matches at enabled cycles 5, 9, 14 within one window.
        run(5, 1'b1);
        chk("t1_m5",  1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0, 2'd1, 1'b0, 1'b0, 2'd2);
        run(3, 1'b1);
        chk("t1_m9",  1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 8'd4, 2'd2, 1'b0, 1'b0, 2'd2);
        run(4, 1'b1);
        chk("t1_m14", 1'b0, 1'b1, 1'b1, 1'b0, 8'd3, 8'd5, 2'd3, 1'b1, 1'b1, 2'd3);
        chk("t1_c15", 1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 8'd5, 2'd0, 1'b1, 1'b0, 2'd3);

        // clr with a coincident match while in ALARM.
        chk("clr_alarm", 1'b0, 1'b1, 1'b1, 1'b1, 8'd0, 8'd0, 2'd0, 1'b0, 1'b0, 2'd1);

        // Matches at 3 and 10, window wraps at 15, match at 17.
        chk("t2_reset", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b0, 2'd0);
        run(3, 1'b1);
        chk("t2_m3",   1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0, 2'd1, 1'b0, 1'b0, 2'd2);
        run(6, 1'b1);
        chk("t2_m10",  1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 8'd7, 2'd2, 1'b0, 1'b0, 2'd2);
        run(4, 1'b1);
        chk("t2_wrap", 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 8'd7, 2'd0, 1'b0, 1'b0, 2'd2);
        run(1, 1'b1);
        chk("t2_m17",  1'b0, 1'b1, 1'b1, 1'b0, 8'd3, 8'd7, 2'd1, 1'b0, 1'b0, 2'd2);

        // Drop enable in TRACK with matches present, then re-enable.
        run(2, 1'b1);
        chk("dis_m", 1'b0, 1'b0, 1'b1, 1'b0, 8'd3, 8'd7, 2'd0, 1'b0, 1'b0, 2'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        run(5, 1'b1);
        chk("re_m5",  1'b0, 1'b1, 1'b1, 1'b0, 8'd4, 8'd7, 2'd1, 1'b0, 1'b0, 2'd2);
        run(4, 1'b1);
        chk("re_m10", 1'b0, 1'b1, 1'b1, 1'b0, 8'd5, 8'd5, 2'd2, 1'b0, 1'b0, 2'd2);
        run(3, 1'b1);
        chk("re_m14", 1'b0, 1'b1, 1'b1, 1'b0, 8'd6, 8'd4, 2'd3, 1'b1, 1'b1, 2'd3);

        // enable low in ALARM holds everything.
        chk("hold_alarm", 1'b0, 1'b0, 1'b1, 1'b0, 8'd6, 8'd4, 2'd3, 1'b1, 1'b0, 2'd3);

        // rst beats clr and match in ALARM.
        chk("rst_all",  1'b1, 1'b1, 1'b1, 1'b1, 8'd0, 8'd0, 2'd0, 1'b0, 1'b0, 2'd0);
        chk("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b0, 2'd0);

        // Match held high: match_count saturates at 255.
        run(2, 1'b1);
        for (int i = 0; i < 254; i++) drive(1'b0, 1'b1, 1'b1, 1'b0);
        chk("sat_255", 1'b0, 1'b1, 1'b1, 1'b0, 8'd255, 8'd1, 2'd2, 1'b1, 1'b0, 2'd3);
        for (int i = 0; i < 44; i++) drive(1'b0, 1'b1, 1'b1, 1'b0);
        chk("sat_300", 1'b0, 1'b1, 1'b1, 1'b0, 8'd255, 8'd1, 2'd3, 1'b1, 1'b0, 2'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
